// File: rtl/difftest_arch_int_reg_tracker_if.sv
// Commit-stage writeback bus observed by the architectural register tracker.
// master: core commit stage (drives); slave: tracker (observes).
interface difftest_arch_int_reg_tracker_if #(
    parameter int NUM_WB = 2,
    parameter int XLEN   = 64
);
    // Per-port writeback valid, port 0 is oldest in program order
    logic [NUM_WB-1:0]      io_wen;
    // Per-port destination register, port k at [5k+4:5k]
    logic [NUM_WB*5-1:0]    io_waddr;
    // Per-port write data, port k at [XLEN*k+XLEN-1:XLEN*k]
    logic [NUM_WB*XLEN-1:0] io_wdata;
    // Single-cycle request to re-report state without a write
    logic                   io_dump;

    modport master (
        output io_wen,
        output io_waddr,
        output io_wdata,
        output io_dump
    );

    modport slave (
        input io_wen,
        input io_waddr,
        input io_wdata,
        input io_dump
    );
endinterface

// File: rtl/difftest_arch_int_reg_tracker.sv
// Shadow architectural integer register file feeding the difftest reporter.
// Ports: clock/reset; wb (commit writeback bus, slave); io_coreid_in;
// enable strobe, io_value_0..31 and io_coreid, all registered.
module difftest_arch_int_reg_tracker #(
    parameter int NUM_WB    = 2,
    parameter int XLEN      = 64,
    parameter int HEARTBEAT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    difftest_arch_int_reg_tracker_if.slave wb,
    input  logic [7:0]            io_coreid_in,
    output logic                  enable,
    output logic [XLEN-1:0]       io_value_0,
    output logic [XLEN-1:0]       io_value_1,
    output logic [XLEN-1:0]       io_value_2,
    output logic [XLEN-1:0]       io_value_3,
    output logic [XLEN-1:0]       io_value_4,
    output logic [XLEN-1:0]       io_value_5,
    output logic [XLEN-1:0]       io_value_6,
    output logic [XLEN-1:0]       io_value_7,
    output logic [XLEN-1:0]       io_value_8,
    output logic [XLEN-1:0]       io_value_9,
    output logic [XLEN-1:0]       io_value_10,
    output logic [XLEN-1:0]       io_value_11,
    output logic [XLEN-1:0]       io_value_12,
    output logic [XLEN-1:0]       io_value_13,
    output logic [XLEN-1:0]       io_value_14,
    output logic [XLEN-1:0]       io_value_15,
    output logic [XLEN-1:0]       io_value_16,
    output logic [XLEN-1:0]       io_value_17,
    output logic [XLEN-1:0]       io_value_18,
    output logic [XLEN-1:0]       io_value_19,
    output logic [XLEN-1:0]       io_value_20,
    output logic [XLEN-1:0]       io_value_21,
    output logic [XLEN-1:0]       io_value_22,
    output logic [XLEN-1:0]       io_value_23,
    output logic [XLEN-1:0]       io_value_24,
    output logic [XLEN-1:0]       io_value_25,
    output logic [XLEN-1:0]       io_value_26,
    output logic [XLEN-1:0]       io_value_27,
    output logic [XLEN-1:0]       io_value_28,
    output logic [XLEN-1:0]       io_value_29,
    output logic [XLEN-1:0]       io_value_30,
    output logic [XLEN-1:0]       io_value_31,
    output logic [7:0]            io_coreid
);

    // A zero HEARTBEAT still needs a legal one-bit counter; it is then
    // held at zero and never expires.
    localparam int HB_W =
        (HEARTBEAT > 0) ? $clog2(HEARTBEAT + 1) : 1;
    localparam int HB_LAST_I =
        (HEARTBEAT > 0) ? HEARTBEAT - 1 : 0;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_LAST_I);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [HB_W-1:0]   hb_cnt;
    logic [XLEN-1:0]   rf [32];

    logic [4:0]        waddr [NUM_WB];
    logic [XLEN-1:0]   wdata [NUM_WB];

    logic              commit;
    logic              hb_exp;
    logic              strobe;

    for (genvar k = 0; k < NUM_WB; k++) begin : g_port
        assign waddr[k] = wb.io_waddr[5*k +: 5];
        assign wdata[k] = wb.io_wdata[XLEN*k +: XLEN];
    end

    // Writes to x0 are still commits even though they store nothing.
    assign commit = |wb.io_wen;
    assign hb_exp = (HEARTBEAT > 0) && (hb_cnt == HB_LAST);
    assign strobe = commit | wb.io_dump | hb_exp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            enable    <= 1'b0;
            hb_cnt    <= '0;
            io_coreid <= 8'd0;
            rf        <= '{default: '0};
        end else begin
            io_coreid <= io_coreid_in;

            // Ascending port order: the youngest port targeting a
            // register is assigned last and therefore wins.
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb.io_wen[k] && (waddr[k] != 5'd0)) begin
                    rf[waddr[k]] <= wdata[k];
                end
            end

            unique case (state)
                INIT: begin
                    // Publish the all-zero state once after reset.
                    enable <= 1'b1;
                    hb_cnt <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    enable <= strobe;
                    if (strobe || (HEARTBEAT == 0)) begin
                        hb_cnt <= '0;
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                default: begin
                    enable <= 1'b0;
                    hb_cnt <= '0;
                    state  <= INIT;
                end
            endcase
        end
    end

    // rf[0] is reset to zero and never written, so x0 reads as 0.
    assign io_value_0  = rf[0];
    assign io_value_1  = rf[1];
    assign io_value_2  = rf[2];
    assign io_value_3  = rf[3];
    assign io_value_4  = rf[4];
    assign io_value_5  = rf[5];
    assign io_value_6  = rf[6];
    assign io_value_7  = rf[7];
    assign io_value_8  = rf[8];
    assign io_value_9  = rf[9];
    assign io_value_10 = rf[10];
    assign io_value_11 = rf[11];
    assign io_value_12 = rf[12];
    assign io_value_13 = rf[13];
    assign io_value_14 = rf[14];
    assign io_value_15 = rf[15];
    assign io_value_16 = rf[16];
    assign io_value_17 = rf[17];
    assign io_value_18 = rf[18];
    assign io_value_19 = rf[19];
    assign io_value_20 = rf[20];
    assign io_value_21 = rf[21];
    assign io_value_22 = rf[22];
    assign io_value_23 = rf[23];
    assign io_value_24 = rf[24];
    assign io_value_25 = rf[25];
    assign io_value_26 = rf[26];
    assign io_value_27 = rf[27];
    assign io_value_28 = rf[28];
    assign io_value_29 = rf[29];
    assign io_value_30 = rf[30];
    assign io_value_31 = rf[31];

endmodule

// File: tb/tb_difftest_arch_int_reg_tracker.sv
// Scoreboard bench for difftest_arch_int_reg_tracker.
// Directed test-plan sequences followed by randomized commit traffic.
module tb_difftest_arch_int_reg_tracker;

    localparam int HB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    difftest_arch_int_reg_tracker_if #(.NUM_WB(2), .XLEN(64)) wb ();

    logic [7:0]  cid_in;
    logic        en;
    logic [7:0]  cid;
    logic [63:0] v0, v1, v2, v3, v4, v5, v6, v7;
    logic [63:0] v8, v9, v10, v11, v12, v13, v14, v15;
    logic [63:0] v16, v17, v18, v19, v20, v21, v22, v23;
    logic [63:0] v24, v25, v26, v27, v28, v29, v30, v31;
    logic [31:0][63:0] dv;

    assign dv = {v31, v30, v29, v28, v27, v26, v25, v24,
                 v23, v22, v21, v20, v19, v18, v17, v16,
                 v15, v14, v13, v12, v11, v10, v9, v8,
                 v7, v6, v5, v4, v3, v2, v1, v0};

    difftest_arch_int_reg_tracker #(
        .NUM_WB(2), .XLEN(64), .HEARTBEAT(HB)
    ) dut (
        .clock(clock), .reset(reset), .wb(wb),
        .io_coreid_in(cid_in), .enable(en),
        .io_value_0(v0),   .io_value_1(v1),
        .io_value_2(v2),   .io_value_3(v3),
        .io_value_4(v4),   .io_value_5(v5),
        .io_value_6(v6),   .io_value_7(v7),
        .io_value_8(v8),   .io_value_9(v9),
        .io_value_10(v10), .io_value_11(v11),
        .io_value_12(v12), .io_value_13(v13),
        .io_value_14(v14), .io_value_15(v15),
        .io_value_16(v16), .io_value_17(v17),
        .io_value_18(v18), .io_value_19(v19),
        .io_value_20(v20), .io_value_21(v21),
        .io_value_22(v22), .io_value_23(v23),
        .io_value_24(v24), .io_value_25(v25),
        .io_value_26(v26), .io_value_27(v27),
        .io_value_28(v28), .io_value_29(v29),
        .io_value_30(v30), .io_value_31(v31),
        .io_coreid(cid)
    );

    typedef struct packed {
        int                tgt;
        logic              en;
        logic [7:0]        cid;
        logic [31:0][63:0] v;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // Reference model: architectural registers plus the cycle of the
    // last report; a heartbeat is due HB cycles after that report.
    logic [63:0] m_rf [32];
    bit          m_init = 1'b1;
    int          m_last = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t zero_e(input int t);
        exp_t e;
        e = '0;
        e.tgt = t;
        return e;
    endfunction

    task automatic step(input bit r, input logic [1:0] wen,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input bit dump, input logic [7:0] c);
        exp_t e;
        int n;
        @(posedge clock);
        #1;
        n = cyc;
        wb.io_wen   = wen;
        wb.io_waddr = {a1, a0};
        wb.io_wdata = {d1, d0};
        wb.io_dump  = dump;
        cid_in      = c;
        #1 reset = r;
        if (r) begin
            // Asynchronous clear: this very cycle already reads zeros.
            if (q.size() > 0 && q[q.size()-1].tgt == n)
                q[q.size()-1] = zero_e(n);
            else
                q.push_back(zero_e(n));
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_init = 1'b1;
            q.push_back(zero_e(n + 1));
        end else begin
            if (wen[0] && a0 != 5'd0) m_rf[a0] = d0;
            if (wen[1] && a1 != 5'd0) m_rf[a1] = d1;
            e = zero_e(n + 1);
            if (m_init) begin
                e.en = 1'b1;
                m_init = 1'b0;
            end else begin
                e.en = (wen != 2'b00) || dump || ((n + 1 - m_last) == HB);
            end
            if (e.en) m_last = n + 1;
            e.cid = c;
            for (int i = 0; i < 32; i++) e.v[i] = m_rf[i];
            q.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            step(1'b0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 8'h3c);
    endtask

    // Monitor: compares every expected entry due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.tgt < cyc) begin
                    failures++;
                    $display("FAIL stale cyc=%0d got=%0d want=%0d",
                             e.tgt, cyc, e.tgt);
                end else begin
                    if (en !== e.en) begin
                        failures++;
                        $display("FAIL enable cyc=%0d got=%0b want=%0b",
                                 cyc, en, e.en);
                    end
                    checks++;
                    if (cid !== e.cid) begin
                        failures++;
                        $display("FAIL coreid cyc=%0d got=%0h want=%0h",
                                 cyc, cid, e.cid);
                    end
                    checks++;
                    if (dv !== e.v) begin
                        failures++;
                        for (int i = 0; i < 32; i++) begin
                            if (dv[i] !== e.v[i]) begin
                                $display("FAIL value x%0d cyc=%0d got=%0h want=%0h",
                                         i, cyc, dv[i], e.v[i]);
                                break;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  wen;
        logic [4:0]  a0, a1;
        logic [63:0] d0, d1;
        bit          r, dump;
        wb.io_wen   = '0;
        wb.io_waddr = '0;
        wb.io_wdata = '0;
        wb.io_dump  = 1'b0;
        cid_in      = 8'h00;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;

        // Reset state, INIT strobe, then idle heartbeats.
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 8'h11);
        idle(10);

        // Two ports, distinct registers.
        step(1'b0, 2'b11, 5'd5, 5'd6, 64'h1111, 64'h2222, 1'b0, 8'h21);
        idle(2);
        // Collision: youngest port wins.
        step(1'b0, 2'b11, 5'd7, 5'd7, 64'hAAAA, 64'hBBBB, 1'b0, 8'h22);
        idle(1);
        // x0 write stores nothing but still strobes.
        step(1'b0, 2'b01, 5'd0, 5'd0, 64'hDEAD, 64'd0, 1'b0, 8'h23);
        idle(6);
        // Commit two cycles after a heartbeat pulse.
        step(1'b0, 2'b10, 5'd0, 5'd9, 64'd0, 64'h9999, 1'b0, 8'h24);
        idle(9);
        // Dump only.
        step(1'b0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1, 8'h25);
        idle(3);
        // Reset while a write is in flight.
        step(1'b1, 2'b01, 5'd12, 5'd0, 64'h5555, 64'd0, 1'b0, 8'h26);
        step(1'b1, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 8'h27);
        idle(7);

        for (int it = 0; it < 2000; it++) begin
            r    = ($urandom_range(0, 299) == 0);
            wen  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            a0   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                               : 5'($urandom);
            a1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                               : 5'($urandom);
            d0   = {$urandom, $urandom};
            d1   = {$urandom, $urandom};
            dump = ($urandom_range(0, 15) == 0);
            step(r, wen, a0, a1, d0, d1, dump, 8'($urandom));
        end
        idle(3);
        @(posedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
